// File: rtl/pwm_sched_pkg.sv
// Shared types, widths and the round-robin pick helper for the breathing-PWM scheduler.
package pwm_sched_pkg;

  localparam int unsigned DUTY_W  = 7;
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned RR_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StArb
  } state_e;

  // First set bit of req at or after start, wrapping modulo n.
  // Returns {found, index}; index is meaningless when found is 0.
  function automatic logic [RR_W:0] next_rr(input logic [MAX_REQ-1:0] req,
                                            input logic [RR_W:0]      n,
                                            input logic [RR_W-1:0]    start);
    logic [RR_W:0] res;
    logic [RR_W:0] j;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = {1'b0, start} + (RR_W+1)'(i);
      if (j >= n) j = j - n;
      if (((RR_W+1)'(i) < n) && !res[RR_W] && req[j[RR_W-1:0]]) begin
        res = {1'b1, j[RR_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_duty_gen.sv
// Free-running PWM counter and duty comparator shared by all requesters.
module pwm_duty_gen import pwm_sched_pkg::*; #(
  parameter int unsigned DUTY_MAX = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam logic [DUTY_W-1:0] CntLast = DUTY_W'(DUTY_MAX - 1);

  logic [DUTY_W-1:0] pwm_cnt_q;

  // PWM period counter, wraps after DUTY_MAX clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == CntLast) ? '0 : pwm_cnt_q + 1'b1;
    end
  end

  // duty==0 never fires, duty==DUTY_MAX always fires.
  assign pwm_out = (pwm_cnt_q < duty);

endmodule

// File: rtl/pwm_breath_scheduler.sv
// Round-robin time-sharing of one breathing PWM among N_REQ requesters.
// Each grant gets one full breath (0 -> DUTY_MAX -> 0), then re-arbitrates.
module pwm_breath_scheduler import pwm_sched_pkg::*; #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CLK_DIV   = 500000,
  parameter int unsigned DUTY_MAX  = 100,
  parameter int unsigned DUTY_STEP = 1,
  parameter int unsigned LED_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic [LED_W-1:0]  led
);

  if (DUTY_MAX < 1 || DUTY_MAX > 127) begin : gen_bad_duty_max
    $error("DUTY_MAX must be in 1..127");
  end
  if (DUTY_STEP < 1 || DUTY_STEP > DUTY_MAX) begin : gen_bad_duty_step
    $error("DUTY_STEP must be in 1..DUTY_MAX");
  end
  if (N_REQ < 1 || N_REQ > MAX_REQ) begin : gen_bad_n_req
    $error("N_REQ must be in 1..32");
  end
  if (CLK_DIV < 1) begin : gen_bad_clk_div
    $error("CLK_DIV must be at least 1");
  end

  localparam int unsigned       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DivLast  = DIV_W'(CLK_DIV - 1);
  localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DutyStep = DUTY_W'(DUTY_STEP);
  localparam logic [RR_W:0]     NReq     = (RR_W+1)'(N_REQ);
  localparam logic [RR_W-1:0]   LastReq  = RR_W'(N_REQ - 1);

  state_e             state_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [RR_W-1:0]    rr_ptr_q;
  logic [RR_W-1:0]    owner_q;
  logic [N_REQ-1:0]   grant_q;
  logic [DUTY_W-1:0]  duty_q;
  logic               dir_q;

  logic               tick;
  logic [MAX_REQ-1:0] req_ext;
  logic               owner_req;
  logic [RR_W-1:0]    owner_inc;
  logic [RR_W-1:0]    rr_start;
  logic [RR_W:0]      pick;
  logic               pick_found;
  logic [RR_W-1:0]    pick_idx;
  logic [N_REQ-1:0]   grant_pick;
  logic [DUTY_W:0]    duty_sum;
  logic [DUTY_W-1:0]  duty_up;
  logic [DUTY_W-1:0]  duty_dn;
  logic               pwm_out;
  logic               pwm_en;

  assign tick      = (div_cnt_q == DivLast);
  assign req_ext   = MAX_REQ'(req);
  assign owner_req = req_ext[owner_q];

  // Arbitration start point and saturating ramp arithmetic.
  always_comb begin
    owner_inc = (owner_q == LastReq) ? '0 : owner_q + 1'b1;
    // In ARB the search starts just past the owner so it is served last.
    rr_start  = (state_q == StArb) ? owner_inc : rr_ptr_q;
    pick      = next_rr(req_ext, NReq, rr_start);
    duty_sum  = {1'b0, duty_q} + {1'b0, DutyStep};
    duty_up   = (duty_sum >= {1'b0, DutyMax}) ? DutyMax : duty_sum[DUTY_W-1:0];
    duty_dn   = (duty_q < DutyStep) ? '0 : duty_q - DutyStep;
  end

  assign pick_found = pick[RR_W];
  assign pick_idx   = pick[RR_W-1:0];
  assign grant_pick = N_REQ'(1) << pick_idx;

  // Arbitration FSM, breath ramp and step divider with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      duty_q    <= '0;
      dir_q     <= 1'b1;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q   <= grant_pick;
            owner_q   <= pick_idx;
            dir_q     <= 1'b1;
            div_cnt_q <= '0;
            state_q   <= StUp;
          end
        end
        StUp: begin
          // Owner dropping its request wins over a coincident tick.
          if (!owner_req) begin
            duty_q  <= '0;
            grant_q <= '0;
            state_q <= StArb;
          end else if (tick) begin
            duty_q <= duty_up;
            if (duty_up == DutyMax) begin
              dir_q   <= 1'b0;
              state_q <= StDown;
            end
          end
        end
        StDown: begin
          if (!owner_req) begin
            duty_q  <= '0;
            grant_q <= '0;
            state_q <= StArb;
          end else if (tick) begin
            duty_q <= duty_dn;
            if (duty_dn == '0) begin
              grant_q <= '0;
              state_q <= StArb;
            end
          end
        end
        StArb: begin
          rr_ptr_q <= owner_inc;
          dir_q    <= 1'b1;
          if (pick_found) begin
            grant_q   <= grant_pick;
            owner_q   <= pick_idx;
            div_cnt_q <= '0;
            state_q   <= StUp;
          end else begin
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pwm_duty_gen #(
    .DUTY_MAX (DUTY_MAX)
  ) u_duty_gen (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign pwm_en = (state_q == StUp) || (state_q == StDown);
  assign led    = pwm_en ? {LED_W{pwm_out}} : '0;
  assign grant  = grant_q;
  assign duty   = duty_q;
  assign dir    = dir_q;

endmodule

// File: tb/tb_pwm_breath_scheduler.sv
// Scoreboard bench: three scheduler instances share one clock.
//   dut0: CLK_DIV=4,  DUTY_MAX=4, DUTY_STEP=1 -- breath, round robin, abort, async reset
//   dut1: CLK_DIV=4,  DUTY_MAX=4, DUTY_STEP=3 -- saturation
//   dut2: CLK_DIV=40, DUTY_MAX=4, DUTY_STEP=1 -- PWM waveform shape
`timescale 1ns/1ps
module tb_pwm_breath_scheduler;

  typedef struct {
    logic [3:0] grant;
    logic [6:0] duty;
    logic       dir;
    int         gap;   // ns since previous observed change, 0 = not checked
  } exp_t;

  typedef struct {
    time         t;
    logic [14:0] led;
  } led_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [3:0]  req0 = '0;
  logic [3:0]  req1 = '0;
  logic [3:0]  req2 = '0;
  logic [3:0]  grant_a [3];
  logic [6:0]  duty_a  [3];
  logic        dir_a   [3];
  logic [14:0] led_a   [3];

  exp_t sbq [3][$];
  led_t led_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pwm_breath_scheduler #(
    .N_REQ(4), .CLK_DIV(4), .DUTY_MAX(4), .DUTY_STEP(1), .LED_W(15)
  ) dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req0),
    .grant(grant_a[0]), .duty(duty_a[0]), .dir(dir_a[0]), .led(led_a[0])
  );

  pwm_breath_scheduler #(
    .N_REQ(4), .CLK_DIV(4), .DUTY_MAX(4), .DUTY_STEP(3), .LED_W(15)
  ) dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req1),
    .grant(grant_a[1]), .duty(duty_a[1]), .dir(dir_a[1]), .led(led_a[1])
  );

  pwm_breath_scheduler #(
    .N_REQ(4), .CLK_DIV(40), .DUTY_MAX(4), .DUTY_STEP(1), .LED_W(15)
  ) dut2 (
    .clk(clk), .rst(rst_v[2]), .req(req2),
    .grant(grant_a[2]), .duty(duty_a[2]), .dir(dir_a[2]), .led(led_a[2])
  );

  task automatic chk(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  task automatic push(input int k, input logic [3:0] g, input logic [6:0] d,
                      input logic dr, input int gap);
    exp_t e;
    e.grant = g;
    e.duty  = d;
    e.dir   = dr;
    e.gap   = gap;
    sbq[k].push_back(e);
  endtask

  // Steps of one full breath after the grant for CLK_DIV=4, DUTY_MAX=4, DUTY_STEP=1.
  task automatic push_breath(input int k, input logic [3:0] g);
    push(k, g, 1, 1'b1, 40);
    push(k, g, 2, 1'b1, 40);
    push(k, g, 3, 1'b1, 40);
    push(k, g, 4, 1'b0, 40);
    push(k, g, 3, 1'b0, 40);
    push(k, g, 2, 1'b0, 40);
    push(k, g, 1, 1'b0, 40);
    push(k, 4'b0000, 0, 1'b0, 40);  // ARB cycle
  endtask

  task automatic push_led(input time t, input logic [14:0] l);
    led_t e;
    e.t   = t;
    e.led = l;
    led_q.push_back(e);
  endtask

  task automatic wait_to(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Per-DUT monitor: on every change of {grant,duty,dir} pop and compare.
  for (genvar k = 0; k < 3; k++) begin : g_mon
    initial begin
      logic [11:0] prev;
      logic [11:0] cur;
      bit          have;
      time         last;
      int          gap;
      exp_t        e;
      logic [14:0] led_req;
      have = 1'b0;
      last = 0;
      prev = '0;
      forever begin
        @(negedge clk or negedge rst_v[k]);
        #1;
        cur = {grant_a[k], duty_a[k], dir_a[k]};
        if (!have || cur !== prev) begin
          gap = int'($time - last);
          if (sbq[k].size() == 0) begin
            chk(1'b0, $sformatf("dut%0d unexpected_change at %0t: got grant=%b duty=%0d dir=%b, required no change",
                                k, $time, grant_a[k], duty_a[k], dir_a[k]));
          end else begin
            e = sbq[k].pop_front();
            chk(grant_a[k] === e.grant && duty_a[k] === e.duty && dir_a[k] === e.dir &&
                (e.gap == 0 || gap == e.gap),
                $sformatf("dut%0d step at %0t: got grant=%b duty=%0d dir=%b gap=%0d, required grant=%b duty=%0d dir=%b gap=%0d",
                          k, $time, grant_a[k], duty_a[k], dir_a[k], gap, e.grant, e.duty, e.dir, e.gap));
            // At duty 0 or full scale the LED level is independent of PWM phase.
            if (e.duty == 7'd0 || e.duty == 7'd4) begin
              led_req = (e.duty == 7'd0) ? 15'h0000 : 15'h7fff;
              chk(led_a[k] === led_req,
                  $sformatf("dut%0d led at %0t: got %h, required %h", k, $time, led_a[k], led_req));
            end
          end
          have = 1'b1;
          prev = cur;
          last = $time;
        end
      end
    end
  end

  // Time-stamped LED waveform checks on dut2.
  initial begin
    led_t l;
    forever begin
      @(negedge clk);
      #1;
      while (led_q.size() > 0 && led_q[0].t <= $time) begin
        l = led_q.pop_front();
        chk(l.t == $time && led_a[2] === l.led,
            $sformatf("dut2 pwm_shape at %0t (due %0t): got %h, required %h", $time, l.t, led_a[2], l.led));
      end
    end
  end

  initial begin
    logic [14:0] shape [8];
    shape = '{15'h7fff, 15'h7fff, 15'h0000, 15'h0000,
              15'h7fff, 15'h7fff, 15'h0000, 15'h0000};

    // dut0: reset, two solo breaths, round robin, abort, async reset mid-breath.
    push(0, 4'b0000, 0, 1'b1, 0);
    push(0, 4'b0001, 0, 1'b1, 0);
    push_breath(0, 4'b0001);
    push(0, 4'b0001, 0, 1'b1, 10);
    push_breath(0, 4'b0001);
    push(0, 4'b0010, 0, 1'b1, 10);
    push_breath(0, 4'b0010);
    push(0, 4'b1000, 0, 1'b1, 10);
    push_breath(0, 4'b1000);
    push(0, 4'b0010, 0, 1'b1, 10);
    push(0, 4'b0010, 1, 1'b1, 40);
    push(0, 4'b0010, 2, 1'b1, 40);
    push(0, 4'b0000, 0, 1'b1, 20);  // abort
    push(0, 4'b0100, 0, 1'b1, 50);
    push_breath(0, 4'b0100);
    push(0, 4'b0100, 0, 1'b1, 10);
    push(0, 4'b0100, 1, 1'b1, 40);
    push(0, 4'b0100, 2, 1'b1, 40);
    push(0, 4'b0100, 3, 1'b1, 40);
    push(0, 4'b0000, 0, 1'b1, 12);  // async reset between edges
    push(0, 4'b0100, 0, 1'b1, 28);  // rr pointer restarted at 0
    push(0, 4'b0100, 1, 1'b1, 40);
    push(0, 4'b0000, 0, 1'b1, 20);  // abort to idle

    // dut1: DUTY_STEP=3 saturates at 4.
    push(1, 4'b0000, 0, 1'b1, 0);
    push(1, 4'b0001, 0, 1'b1, 0);
    push(1, 4'b0001, 3, 1'b1, 40);
    push(1, 4'b0001, 4, 1'b0, 40);
    push(1, 4'b0001, 1, 1'b0, 40);
    push(1, 4'b0000, 0, 1'b0, 40);
    push(1, 4'b0001, 0, 1'b1, 10);
    push(1, 4'b0000, 0, 1'b1, 30);

    // dut2: slow ramp for PWM shape.
    push(2, 4'b0000, 0, 1'b1, 0);
    push(2, 4'b0001, 0, 1'b1, 0);
    push(2, 4'b0001, 1, 1'b1, 400);
    push(2, 4'b0001, 2, 1'b1, 400);
    push(2, 4'b0001, 3, 1'b1, 400);
    push(2, 4'b0001, 4, 1'b0, 400);
    push(2, 4'b0001, 3, 1'b0, 400);
    for (int i = 0; i < 8; i++) push_led(901 + 10 * i, shape[i]);
    for (int i = 0; i < 4; i++) push_led(1701 + 10 * i, 15'h7fff);

    wait_to(1);    rst_v = 3'b000;
    wait_to(20);   rst_v = 3'b111;
    wait_to(30);   req0 = 4'b0001; req1 = 4'b0001; req2 = 4'b0001;
    wait_to(230);  req1 = 4'b0000;
    wait_to(400);  req0 = 4'b1011;
    wait_to(800);  req0 = 4'b1010;
    wait_to(1450); req0 = 4'b0000;
    wait_to(1500); req0 = 4'b0100;
    wait_to(1960); req0 = 4'b1100;
    wait_to(1972); rst_v[0] = 1'b0;
    wait_to(1990); rst_v[0] = 1'b1;
    wait_to(2050); req0 = 4'b0000;
    wait_to(2300);

    for (int k = 0; k < 3; k++) begin
      chk(sbq[k].size() == 0,
          $sformatf("dut%0d drained: got %0d pending steps, required 0", k, sbq[k].size()));
    end
    chk(led_q.size() == 0,
        $sformatf("dut2 led_drained: got %0d pending samples, required 0", led_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
